stack_mem_ctrl: RTL and testbench
=================================

Name: stack_mem_ctrl

Overview:
Sequencer sitting between the stack calculator's command decoder and the 4-bit `memory` array. Turns PUSH/POP/CLEAR commands into timed `memory` mode/address/data cycles. Owns the stack pointer and reports depth, full, empty and per-command responses. It is the only master of the `memory` ports.

Parameters:
ADDR_BITS, 4, address width; equals `MEMORY_ADDR_BITS`; stack capacity is 2**ADDR_BITS entries.
DATA_BITS, 4, entry width; equals the `memory` data width.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command; high only in IDLE.
cmd_op  in  2  0=NOP, 1=PUSH, 2=POP, 3=CLEAR.
cmd_data  in  DATA_BITS  PUSH operand.
rsp_valid  out  1  one-cycle response pulse.
rsp_data  out  DATA_BITS  POP result; 0 for all other responses.
rsp_err  out  1  qualifies rsp_valid: overflow or underflow.
depth  out  ADDR_BITS+1  current entry count, 0..2**ADDR_BITS.
full  out  1  depth == 2**ADDR_BITS.
empty  out  1  depth == 0.
mem_mode  out  2  to `memory` mode; values `MEMORY_MODE_NONE` / `MEMORY_MODE_WRITE` / `MEMORY_MODE_CLEAR`.
mem_addr  out  ADDR_BITS  to `memory` address.
mem_wdata  out  DATA_BITS  to `memory` data_in.
mem_rdata  in  DATA_BITS  from `memory` data_out.

Behaviour:
- FSM states: INIT, IDLE, WR, RD0, RD1, CLR, RESP. All outputs are registered.
- Reset values (in the cycle after rst is sampled high): state=INIT, depth=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_mode=NONE, mem_addr=0, mem_wdata=0.
- INIT:
  - mem_mode=CLEAR for exactly one cycle, then go to IDLE.
  - Produces no response. Zeroes the array after every reset.
- Handshake:
  - Accept when cmd_valid && cmd_ready at edge T.
  - Operands are latched at T.
  - cmd_ready=0 from T+1 until the FSM returns to IDLE.
- NOP: accepted, no response, FSM stays in IDLE.
- PUSH, not full:
  - Cycle T+1: state WR, mem_mode=WRITE, mem_addr=depth, mem_wdata=latched data.
  - Cycle T+2: state RESP, rsp_valid=1, rsp_err=0, depth incremented.
- POP, not empty:
  - Cycle T+1: state RD0, mem_mode=NONE, mem_addr=depth-1.
  - Cycle T+2: state RD1, same address; mem_rdata is captured at the end of this cycle.
  - Cycle T+3: state RESP, rsp_valid=1, rsp_data=captured value, depth decremented.
  - The popped cell is not cleared.
- CLEAR:
  - Cycle T+1: state CLR, mem_mode=CLEAR.
  - Cycle T+2: state RESP, rsp_valid=1, depth=0.
- PUSH when full, or POP when empty:
  - No memory cycle.
  - Cycle T+1: state RESP, rsp_valid=1, rsp_err=1, rsp_data=0, depth unchanged.
- RESP lasts exactly one cycle, then IDLE.
- Minimum command spacing: PUSH/CLEAR every 3 cycles, POP every 4, errors every 2.
- mem_mode=NONE and mem_addr=0 in IDLE and RESP.
- mem_wdata holds its last value; it is only meaningful in WR.
- depth never wraps. full and empty are combinational from depth and are mutually exclusive.
- rst high in any state, mid-operation included:
  - Aborts the command with no response.
  - Any pending write is dropped: mem_mode=NONE during reset.
  - Re-enters INIT.
- rsp_valid is independent of cmd_valid; there is no backpressure on responses.

Test Plan:
- Reset: hold rst 2 cycles, then release -> exactly one cycle with mem_mode=CLEAR, then cmd_ready=1, depth=0, empty=1, no rsp_valid.
- PUSH 0xA, PUSH 0x3, POP, POP -> write at addr 0 then addr 1; pops return 0x3 then 0xA with rsp_err=0; POP rsp_valid exactly 3 cycles after accept; final depth=0.
- With ADDR_BITS=4, 16 PUSHes of values 0..F -> full=1, depth=16; 17th PUSH -> rsp_err=1, no WRITE cycle, depth stays 16.
- POP on empty -> rsp_valid and rsp_err at T+1, rsp_data=0, mem_mode stays NONE.
- PUSH 5, PUSH 6, CLEAR -> one CLEAR cycle, depth=0; subsequent POP -> underflow error.
- Assert rst during RD0 of a POP -> no rsp_valid, INIT clear cycle follows, depth=0.

Source files
------------

// File: rtl/stack_mem_ctrl.sv
// Stack sequencer between the calculator command decoder and the memory array.
// Owns the stack pointer and turns PUSH/POP/CLEAR into timed memory cycles.
module stack_mem_ctrl #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_err,
  output logic [ADDR_BITS:0]   depth,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam logic [1:0] MEMORY_MODE_NONE  = 2'd0;
  localparam logic [1:0] MEMORY_MODE_WRITE = 2'd1;
  localparam logic [1:0] MEMORY_MODE_CLEAR = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_PUSH  = 2'd1;
  localparam logic [1:0] OP_POP   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [ADDR_BITS:0] CAPACITY = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {INIT, IDLE, WR, RD0, RD1, CLR, RESP} state_t;

  state_t                 state, state_n;
  logic                   cmd_ready_n;
  logic                   rsp_valid_n;
  logic [DATA_BITS-1:0]   rsp_data_n;
  logic                   rsp_err_n;
  logic [ADDR_BITS:0]     depth_n;
  logic [ADDR_BITS:0]     depth_dec;
  logic [1:0]             mem_mode_n;
  logic [ADDR_BITS-1:0]   mem_addr_n;
  logic [DATA_BITS-1:0]   mem_wdata_n;

  assign full      = (depth == CAPACITY);
  assign empty     = (depth == '0);
  assign depth_dec = depth - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      depth     <= '0;
      mem_mode  <= MEMORY_MODE_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
      depth     <= depth_n;
      mem_mode  <= mem_mode_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

  // Every output is computed here for the next state and registered above.
  always_comb begin
    state_n     = state;
    cmd_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_data_n  = '0;
    rsp_err_n   = 1'b0;
    depth_n     = depth;
    mem_mode_n  = MEMORY_MODE_NONE;
    mem_addr_n  = '0;
    mem_wdata_n = mem_wdata;

    case (state)
      INIT: begin
        // The registered mode doubles as the "clear already issued" flag.
        if (mem_mode == MEMORY_MODE_CLEAR) begin
          state_n     = IDLE;
          cmd_ready_n = 1'b1;
        end else begin
          mem_mode_n = MEMORY_MODE_CLEAR;
        end
      end

      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_PUSH: begin
              cmd_ready_n = 1'b0;
              if (full) begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
              end else begin
                state_n     = WR;
                mem_mode_n  = MEMORY_MODE_WRITE;
                mem_addr_n  = depth[ADDR_BITS-1:0];
                mem_wdata_n = cmd_data;
              end
            end
            OP_POP: begin
              cmd_ready_n = 1'b0;
              if (empty) begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
              end else begin
                state_n    = RD0;
                mem_addr_n = depth_dec[ADDR_BITS-1:0];
              end
            end
            OP_CLEAR: begin
              cmd_ready_n = 1'b0;
              state_n     = CLR;
              mem_mode_n  = MEMORY_MODE_CLEAR;
            end
            default: ;
          endcase
        end
      end

      WR: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        depth_n     = depth + 1'b1;
      end

      RD0: begin
        state_n    = RD1;
        mem_addr_n = mem_addr;
      end

      RD1: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = mem_rdata;
        depth_n     = depth_dec;
      end

      CLR: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
        depth_n     = '0;
      end

      RESP: begin
        state_n     = IDLE;
        cmd_ready_n = 1'b1;
      end

      default: state_n = INIT;
    endcase
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl with a registered-read model of the memory array.
module tb_stack_mem_ctrl;

  localparam int ADDR_BITS = 4;
  localparam int DATA_BITS = 4;

  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_WRITE = 2'd1;
  localparam logic [1:0] MODE_CLEAR = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_PUSH  = 2'd1;
  localparam logic [1:0] OP_POP   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [DATA_BITS-1:0] cmd_data;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;
  logic                 rsp_err;
  logic [ADDR_BITS:0]   depth;
  logic                 full;
  logic                 empty;
  logic [1:0]           mem_mode;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  logic [DATA_BITS-1:0] mem_array [2**ADDR_BITS];

  int check_count = 0;
  int pass_count  = 0;

  stack_mem_ctrl #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: write or clear on the edge, registered read of the addressed cell.
  always @(posedge clk) begin
    mem_rdata <= mem_array[mem_addr];
    if (mem_mode == MODE_WRITE) mem_array[mem_addr] <= mem_wdata;
    else if (mem_mode == MODE_CLEAR)
      for (int i = 0; i < 2**ADDR_BITS; i++) mem_array[i] <= '0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one command for one accepting edge; returns at the negedge of cycle T+1.
  task automatic applyStimulus(input logic [1:0] op, input logic [DATA_BITS-1:0] data);
    checkOutput("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
  endtask

  task automatic doPush(input logic [3:0] value, input logic [4:0] exp_depth_before);
    applyStimulus(OP_PUSH, value);
    checkOutput("push_wr_mode", mem_mode, MODE_WRITE);
    checkOutput("push_wr_addr", mem_addr, exp_depth_before);
    checkOutput("push_wr_data", mem_wdata, value);
    checkOutput("push_wr_ready", cmd_ready, 0);
    step();
    checkOutput("push_rsp_valid", rsp_valid, 1);
    checkOutput("push_rsp_err", rsp_err, 0);
    checkOutput("push_depth", depth, exp_depth_before + 1);
    checkOutput("push_rsp_mode", mem_mode, MODE_NONE);
    step();
    checkOutput("push_idle_rsp", rsp_valid, 0);
  endtask

  task automatic doPop(input logic [3:0] exp_value, input logic [4:0] exp_depth_before);
    applyStimulus(OP_POP, 4'h0);
    checkOutput("pop_rd0_mode", mem_mode, MODE_NONE);
    checkOutput("pop_rd0_addr", mem_addr, exp_depth_before - 1);
    checkOutput("pop_rd0_rsp", rsp_valid, 0);
    step();
    checkOutput("pop_rd1_addr", mem_addr, exp_depth_before - 1);
    checkOutput("pop_rd1_rsp", rsp_valid, 0);
    step();
    checkOutput("pop_rsp_valid", rsp_valid, 1);
    checkOutput("pop_rsp_data", rsp_data, exp_value);
    checkOutput("pop_rsp_err", rsp_err, 0);
    checkOutput("pop_depth", depth, exp_depth_before - 1);
    step();
    checkOutput("pop_idle_rsp", rsp_valid, 0);
  endtask

  task automatic doError(input logic [1:0] op, input logic [4:0] exp_depth);
    applyStimulus(op, 4'hF);
    checkOutput("err_rsp_valid", rsp_valid, 1);
    checkOutput("err_rsp_err", rsp_err, 1);
    checkOutput("err_rsp_data", rsp_data, 0);
    checkOutput("err_mode", mem_mode, MODE_NONE);
    checkOutput("err_depth", depth, exp_depth);
    step();
    checkOutput("err_idle_ready", cmd_ready, 1);
    checkOutput("err_idle_rsp", rsp_valid, 0);
  endtask

  task automatic doClear();
    applyStimulus(OP_CLEAR, 4'h0);
    checkOutput("clr_mode", mem_mode, MODE_CLEAR);
    step();
    checkOutput("clr_rsp_valid", rsp_valid, 1);
    checkOutput("clr_rsp_err", rsp_err, 0);
    checkOutput("clr_depth", depth, 0);
    checkOutput("clr_rsp_mode", mem_mode, MODE_NONE);
    step();
  endtask

  task automatic checkInitSequence();
    checkOutput("rst_ready", cmd_ready, 0);
    checkOutput("rst_mode", mem_mode, MODE_NONE);
    checkOutput("rst_depth", depth, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    step();
    checkOutput("init_clear_mode", mem_mode, MODE_CLEAR);
    checkOutput("init_ready", cmd_ready, 0);
    checkOutput("init_rsp", rsp_valid, 0);
    step();
    checkOutput("init_done_mode", mem_mode, MODE_NONE);
    checkOutput("init_done_ready", cmd_ready, 1);
    checkOutput("init_done_depth", depth, 0);
    checkOutput("init_done_empty", empty, 1);
    checkOutput("init_done_full", full, 0);
    checkOutput("init_done_rsp", rsp_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_BITS; i++) mem_array[i] = 4'h5;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    step();
    step();
    step();
    checkInitSequence();

    doPush(4'hA, 5'd0);
    doPush(4'h3, 5'd1);
    doPop(4'h3, 5'd2);
    doPop(4'hA, 5'd1);
    checkOutput("pair_empty", empty, 1);

    doError(OP_POP, 5'd0);

    applyStimulus(OP_NOP, 4'h9);
    checkOutput("nop_ready", cmd_ready, 1);
    checkOutput("nop_rsp", rsp_valid, 0);
    checkOutput("nop_mode", mem_mode, MODE_NONE);

    for (int i = 0; i < 16; i++) doPush(4'(i), 5'(i));
    checkOutput("fill_full", full, 1);
    checkOutput("fill_empty", empty, 0);
    checkOutput("fill_depth", depth, 16);
    doError(OP_PUSH, 5'd16);
    doPop(4'hF, 5'd16);
    checkOutput("after_pop_full", full, 0);
    doPop(4'hE, 5'd15);

    doClear();
    checkOutput("clr_empty", empty, 1);
    checkOutput("clr_mem_cell0", mem_array[0], 0);
    doPush(4'h5, 5'd0);
    doPush(4'h6, 5'd1);
    doClear();
    doError(OP_POP, 5'd0);

    doPush(4'h7, 5'd0);
    applyStimulus(OP_POP, 4'h0);
    checkOutput("abort_rd0_addr", mem_addr, 0);
    rst = 1'b1;
    step();
    checkOutput("abort_rsp", rsp_valid, 0);
    checkOutput("abort_depth", depth, 0);
    checkInitSequence();
    checkOutput("abort_mem_cell0", mem_array[0], 0);
    doError(OP_POP, 5'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
